// File: rtl/gray_step_monitor.sv
// Gray step monitor: decodes each accepted Gray word back to binary and checks that
// consecutive samples differ by one bit, tracking direction, error totals and lock state.
module gray_step_monitor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned RELOCK    = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] G,
  input  logic             G_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] bin,
  output logic             bin_valid,
  output logic             step_err,
  output logic             dir,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned RunMax = (ERR_LIMIT > RELOCK) ? ERR_LIMIT : RELOCK;
  localparam int unsigned RunW   = $clog2(RunMax + 1);

  typedef enum logic [1:0] {StEmpty, StTrack, StFault} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  g_prev_q, g_prev_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic              bin_valid_q, bin_valid_d;
  logic              step_err_q, step_err_d;
  logic              dir_q, dir_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [RunW-1:0]   err_run_q, err_run_d;
  logic [RunW-1:0]   good_run_q, good_run_d;

  logic [WIDTH-1:0]  bin_new;
  logic [WIDTH-1:0]  bin_inc;
  logic [WIDTH-1:0]  diff;
  logic              is_repeat;
  logic              is_legal;
  logic [RunW-1:0]   err_run_inc;
  logic [RunW-1:0]   good_run_inc;
  logic [CNT_W-1:0]  err_count_inc;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign bin_new   = gray2bin(G);
  assign bin_inc   = bin_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign diff      = G ^ g_prev_q;
  assign is_repeat = (diff == '0);
  assign is_legal  = $onehot(diff);

  // Run counters saturate at their limits so long runs cannot wrap back to zero.
  assign err_run_inc   = (err_run_q >= RunW'(ERR_LIMIT)) ? err_run_q : err_run_q + RunW'(1);
  assign good_run_inc  = (good_run_q >= RunW'(RELOCK)) ? good_run_q : good_run_q + RunW'(1);
  assign err_count_inc = (err_count_q == '1) ? err_count_q : err_count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    g_prev_d    = g_prev_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    step_err_d  = 1'b0;
    dir_d       = dir_q;
    err_count_d = err_count_q;
    err_run_d   = err_run_q;
    good_run_d  = good_run_q;

    if (clr) begin
      state_d     = StEmpty;
      err_count_d = '0;
      err_run_d   = '0;
      good_run_d  = '0;
    end else if (G_valid) begin
      g_prev_d    = G;
      bin_d       = bin_new;
      bin_valid_d = 1'b1;
      case (state_q)
        StTrack, StFault: begin
          if (is_repeat) begin
            // Repeat: nothing but the pulse.
          end else if (is_legal) begin
            dir_d      = (bin_new == bin_inc);
            err_run_d  = '0;
            good_run_d = good_run_inc;
            if (state_q == StFault && good_run_inc >= RunW'(RELOCK)) begin
              state_d = StTrack;
            end
          end else begin
            step_err_d  = 1'b1;
            err_count_d = err_count_inc;
            err_run_d   = err_run_inc;
            good_run_d  = '0;
            if (state_q == StTrack && err_run_inc >= RunW'(ERR_LIMIT)) begin
              state_d = StFault;
            end
          end
        end
        default: state_d = StTrack;
      endcase
    end

    locked_d = (state_d == StTrack);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      g_prev_q    <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      dir_q       <= 1'b1;
      locked_q    <= 1'b0;
      err_count_q <= '0;
      err_run_q   <= '0;
      good_run_q  <= '0;
    end else begin
      state_q     <= state_d;
      g_prev_q    <= g_prev_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      step_err_q  <= step_err_d;
      dir_q       <= dir_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
      err_run_q   <= err_run_d;
      good_run_q  <= good_run_d;
    end
  end

  assign bin       = bin_q;
  assign bin_valid = bin_valid_q;
  assign step_err  = step_err_q;
  assign dir       = dir_q;
  assign locked    = locked_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: table of vectors with hand-derived expectations, queued as
// they are driven and compared after the edge; a CNT_W=2 copy checks counter saturation.
module tb_gray_step_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] G;
  logic       G_valid;
  logic       clr;

  logic [3:0] bin, s_bin;
  logic       bin_valid, s_bin_valid;
  logic       step_err, s_step_err;
  logic       dir, s_dir;
  logic       locked, s_locked;
  logic [7:0] err_count;
  logic [1:0] s_err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int g; int v; int c;
    int bin; int bv; int se; int dir; int lk; int ec;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  gray_step_monitor u_dut (
    .clk       (clk),
    .reset     (reset),
    .G         (G),
    .G_valid   (G_valid),
    .clr       (clr),
    .bin       (bin),
    .bin_valid (bin_valid),
    .step_err  (step_err),
    .dir       (dir),
    .locked    (locked),
    .err_count (err_count)
  );

  gray_step_monitor #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .G         (G),
    .G_valid   (G_valid),
    .clr       (clr),
    .bin       (s_bin),
    .bin_valid (s_bin_valid),
    .step_err  (s_step_err),
    .dir       (s_dir),
    .locked    (s_locked),
    .err_count (s_err_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(input int g, input int v, input int c, input int b,
                              input int bv, input int se, input int d, input int lk,
                              input int ec);
    vec_t r;
    r.g = g; r.v = v; r.c = c; r.bin = b; r.bv = bv; r.se = se; r.dir = d; r.lk = lk;
    r.ec = ec;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, " bin"}, 32'(bin), 0);
    chk({tag, " bin_valid"}, 32'(bin_valid), 0);
    chk({tag, " step_err"}, 32'(step_err), 0);
    chk({tag, " dir"}, 32'(dir), 1);
    chk({tag, " locked"}, 32'(locked), 0);
    chk({tag, " err_count"}, 32'(err_count), 0);
    chk({tag, " sat err_count"}, 32'(s_err_count), 0);
  endtask

  task automatic compare(input int idx);
    vec_t  e;
    string t;
    t = $sformatf("vec%0d", idx);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", t);
    end else begin
      e = exp_q.pop_front();
      chk({t, " bin"}, 32'(bin), e.bin);
      chk({t, " bin_valid"}, 32'(bin_valid), e.bv);
      chk({t, " step_err"}, 32'(step_err), e.se);
      chk({t, " dir"}, 32'(dir), e.dir);
      chk({t, " locked"}, 32'(locked), e.lk);
      chk({t, " err_count"}, 32'(err_count), e.ec);
      chk({t, " sat err_count"}, 32'(s_err_count), (e.ec > 3) ? 3 : e.ec);
      chk({t, " sat step_err"}, 32'(s_step_err), e.se);
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    @(negedge clk);
    G       = 4'(v.g);
    G_valid = 1'(v.v);
    clr     = 1'(v.c);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    G       = 4'b0000;
    G_valid = 1'b0;
    clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    //             G      v  c  bin bv se dir lk ec
    tbl.push_back(mk(4'b0010, 1, 0,  3, 1, 0, 1, 1, 0)); // first sample, no check
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(4'b0001, 1, 0,  1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(4'b0011, 1, 0,  2, 1, 0, 1, 1, 0));
    tbl.push_back(mk(4'b0010, 1, 0,  3, 1, 0, 1, 1, 0));
    tbl.push_back(mk(4'b0110, 1, 0,  4, 1, 0, 1, 1, 0));
    tbl.push_back(mk(4'b0110, 0, 0,  4, 0, 0, 1, 1, 0)); // idle
    tbl.push_back(mk(4'b1000, 1, 1,  4, 0, 0, 1, 0, 0)); // clr beats valid
    tbl.push_back(mk(4'b1000, 1, 0, 15, 1, 0, 1, 1, 0));
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 0, 1, 1, 0)); // 15 -> 0 wraps up
    tbl.push_back(mk(4'b1000, 1, 0, 15, 1, 0, 0, 1, 0)); // 0 -> 15 wraps down
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(4'b0011, 1, 0,  2, 1, 1, 1, 1, 1));
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 1, 1, 1, 2));
    tbl.push_back(mk(4'b0011, 1, 0,  2, 1, 1, 1, 0, 3)); // third error drops lock
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 1, 1, 0, 4));
    tbl.push_back(mk(4'b0001, 1, 0,  1, 1, 0, 1, 0, 4));
    tbl.push_back(mk(4'b0011, 1, 0,  2, 1, 0, 1, 1, 4)); // second clean step relocks
    tbl.push_back(mk(4'b0010, 1, 0,  3, 1, 0, 1, 1, 4));
    tbl.push_back(mk(4'b0110, 1, 0,  4, 1, 0, 1, 1, 4));
    tbl.push_back(mk(4'b0110, 1, 0,  4, 1, 0, 1, 1, 4)); // repeats
    tbl.push_back(mk(4'b0110, 1, 0,  4, 1, 0, 1, 1, 4));
    tbl.push_back(mk(4'b0110, 1, 0,  4, 1, 0, 1, 1, 4));
    tbl.push_back(mk(4'b0110, 0, 0,  4, 0, 0, 1, 1, 4));
    tbl.push_back(mk(4'b0010, 1, 0,  3, 1, 0, 0, 1, 4)); // count down
    tbl.push_back(mk(4'b0011, 1, 0,  2, 1, 0, 0, 1, 4));
    tbl.push_back(mk(4'b0001, 1, 0,  1, 1, 0, 0, 1, 4));
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 0, 0, 1, 4));
    tbl.push_back(mk(4'b1111, 1, 1,  0, 0, 0, 0, 0, 0)); // clr with valid
    tbl.push_back(mk(4'b1111, 1, 0, 10, 1, 0, 0, 1, 0)); // d=4 but EMPTY
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(4'b0001, 1, 0,  1, 1, 0, 1, 1, 1)); // clean step clears error run
    tbl.push_back(mk(4'b0010, 1, 0,  3, 1, 1, 1, 1, 2));
    tbl.push_back(mk(4'b0001, 1, 0,  1, 1, 1, 1, 1, 3));
    tbl.push_back(mk(4'b0100, 1, 0,  7, 1, 1, 1, 0, 4));
    tbl.push_back(mk(4'b0100, 1, 0,  7, 1, 0, 1, 0, 4)); // repeat in FAULT
    tbl.push_back(mk(4'b0101, 1, 0,  6, 1, 0, 0, 0, 4));
    tbl.push_back(mk(4'b0011, 1, 0,  2, 1, 1, 0, 0, 5)); // error clears good run
    tbl.push_back(mk(4'b0001, 1, 0,  1, 1, 0, 0, 0, 5));
    tbl.push_back(mk(4'b0000, 1, 0,  0, 1, 0, 0, 1, 5));
    tbl.push_back(mk(4'b0011, 1, 0,  2, 1, 1, 0, 1, 6));

    foreach (tbl[i]) drive(tbl[i], i);

    // Asynchronous reset between edges while step_err is high and dir is 0.
    #2;
    reset   = 1'b1;
    G_valid = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk);
    reset = 1'b0;
    drive(mk(4'b1111, 1, 0, 10, 1, 0, 1, 1, 0), 100); // treated as first sample
    drive(mk(4'b1111, 0, 0, 10, 0, 0, 1, 1, 0), 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
